// File: rtl/wdecoder.sv
// Raster regenerator: buffers pixel bytes in a 4-entry FIFO and replays them against free-running h/v timing.
// Optional macro WDEC_UNDERFLOW_CNT_EN adds a saturating 8-bit underflow counter output.
module wdecoder #(
  parameter int H_ACTIVE = 8,
  parameter int H_BLANK  = 4,
  parameter int V_ACTIVE = 4,
  parameter int V_BLANK  = 2
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       vsync,
  output logic       hsync,
  output logic [7:0] dout,
  output logic       underflow
`ifdef WDEC_UNDERFLOW_CNT_EN
  , output logic [7:0] underflow_cnt
`endif
);

  // state | meaning
  // IDLE  | prefilling the FIFO; counters held at 0, video outputs 0
  // RUN   | raster timing free-runs until reset
  typedef enum logic {IDLE, RUN} state_t;

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

  state_t          state_q, state_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic [VW-1:0]   vcnt, vcnt_nxt;
  logic [7:0]      mem [4];
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      count;
  logic            push, pop, active;
  logic            vsync_nxt, hsync_nxt, underflow_nxt;
  logic [7:0]      dout_nxt;

  assign din_ready = (count < 3'd4);
  assign push      = din_valid && din_ready;

  always_comb begin
    state_nxt     = state_q;
    hcnt_nxt      = hcnt;
    vcnt_nxt      = vcnt;
    active        = 1'b0;
    pop           = 1'b0;
    vsync_nxt     = 1'b0;
    hsync_nxt     = 1'b0;
    underflow_nxt = 1'b0;
    dout_nxt      = 8'd0;
    case (state_q)
      IDLE: begin
        if (count == 3'd4) state_nxt = RUN;
      end
      RUN: begin
        active = (hcnt < H_ACT) && (vcnt < V_ACT);
        // pop decision uses the pre-push count, so a byte pushed this cycle is never bypassed
        pop           = active && (count != 3'd0);
        hsync_nxt     = active;
        underflow_nxt = active && (count == 3'd0);
        dout_nxt      = pop ? mem[rd_ptr] : 8'd0;
        vsync_nxt     = (vcnt >= V_ACT);
        if (hcnt == H_LAST) begin
          hcnt_nxt = '0;
          vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      vsync     <= 1'b0;
      hsync     <= 1'b0;
      underflow <= 1'b0;
      dout      <= 8'd0;
    end else begin
      state_q   <= state_nxt;
      hcnt      <= hcnt_nxt;
      vcnt      <= vcnt_nxt;
      vsync     <= vsync_nxt;
      hsync     <= hsync_nxt;
      underflow <= underflow_nxt;
      dout      <= dout_nxt;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= din;
  end

`ifdef WDEC_UNDERFLOW_CNT_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      underflow_cnt <= 8'd0;
    else if (underflow_nxt && (underflow_cnt != 8'hFF))
      underflow_cnt <= underflow_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_wdecoder.sv
// Self-checking bench for wdecoder: queue/position model checked every cycle plus directed literal checks.
module tb_wdecoder;
  localparam int H_A = 8, H_B = 4, V_A = 4, V_B = 2;
  localparam int HT = H_A + H_B, VT = V_A + V_B;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'd0;
  logic       din_valid = 1'b0;
  logic       din_ready, vsync, hsync, underflow;
  logic [7:0] dout;
`ifdef WDEC_UNDERFLOW_CNT_EN
  logic [7:0] underflow_cnt;
`endif

  always #5 pclk = ~pclk;

  wdecoder #(.H_ACTIVE(H_A), .H_BLANK(H_B), .V_ACTIVE(V_A), .V_BLANK(V_B)) dut (
    .pclk(pclk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .vsync(vsync), .hsync(hsync), .dout(dout), .underflow(underflow)
`ifdef WDEC_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // model: FIFO as a queue, raster position as a plain cycle index since RUN began
  logic [7:0] mq[$];
  bit         m_run;
  int         m_pos, sz0, h, v, e_ucnt;
  bit         acc, e_hs, e_vs, e_uf;
  logic [7:0] e_dout;

  initial forever begin
    @(posedge pclk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); m_run = 0; m_pos = 0;
      e_dout = 8'd0; e_hs = 0; e_vs = 0; e_uf = 0; e_ucnt = 0;
    end else begin
      sz0 = mq.size();
      acc = din_valid && (sz0 < 4);
      e_dout = 8'd0; e_hs = 0; e_vs = 0; e_uf = 0;
      if (m_run) begin
        h = m_pos % HT;
        v = (m_pos / HT) % VT;
        e_vs = (v >= V_A);
        if (h < H_A && v < V_A) begin
          e_hs = 1;
          if (sz0 > 0) e_dout = mq.pop_front();
          else begin
            e_uf = 1;
            if (e_ucnt < 255) e_ucnt++;
          end
        end
        m_pos++;
      end else if (sz0 == 4) begin
        m_run = 1; m_pos = 0;
      end
      if (acc) mq.push_back(din);
    end
  end

  initial forever begin
    @(negedge pclk);
    check("din_ready", din_ready, (mq.size() < 4));
    check("vsync", vsync, e_vs);
    check("hsync", hsync, e_hs);
    check("dout", dout, e_dout);
    check("underflow", underflow, e_uf);
`ifdef WDEC_UNDERFLOW_CNT_EN
    check("underflow_cnt", underflow_cnt, e_ucnt);
`endif
  end

  // feeder: offers bytes nb..feed_last back to back, advancing only on acceptance
  int nb = 0, feed_last = 0;
  bit feed_en = 0;
  initial forever begin
    @(negedge pclk);
    if (feed_en && nb <= feed_last) begin
      din = 8'(nb); din_valid = 1'b1;
      if (din_ready) nb++;
    end else begin
      din = 8'd0; din_valid = 1'b0;
    end
  end

  task automatic start_feed(input int first, input int last);
    @(posedge pclk); #1;
    nb = first; feed_last = last; feed_en = 1;
  endtask

  // returns on the negedge where the first pixel (hcnt=0, vcnt=0) is visible on the outputs
  task automatic prefill(input int first);
    bit full = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (!din_ready) begin full = 1; break; end
    end
    check("prefill_full_seen", full, 1);
    check("prefill_ready_low", din_ready, 0);
    @(negedge pclk);
    check("run_first_cycle_hsync", hsync, 0);
    @(negedge pclk);
    check("first_pixel_dout", dout, first);
    check("first_pixel_hsync", hsync, 1);
  endtask

  task automatic reset_now();
    #1 rst_n = 1'b0; feed_en = 0; din_valid = 1'b0;
    #1;
    check("rst_async_hsync", hsync, 0);
    check("rst_async_vsync", vsync, 0);
    check("rst_async_dout", dout, 0);
    check("rst_async_underflow", underflow, 0);
    check("rst_async_ready", din_ready, 1);
    @(negedge pclk); @(negedge pclk);
    rst_n = 1'b1;
  endtask

  logic       hs_arr [72];
  logic       vs_arr [72];
  logic       uf_arr [72];
  logic [7:0] pix[$];

  initial begin
    int hs_line, vs_tot, uf_tot, errs;
    // reset and idle
    repeat (3) @(posedge pclk);
    #1;
    check("rst_hold_ready", din_ready, 1);
    @(negedge pclk); rst_n = 1'b1;
    @(negedge pclk);
    check("rst_rel_vsync", vsync, 0);
    check("rst_rel_hsync", hsync, 0);
    check("rst_rel_underflow", underflow, 0);
    check("rst_rel_dout", dout, 0);
    check("rst_rel_ready", din_ready, 1);
    repeat (5) @(negedge pclk);
    check("idle_no_hsync", hsync, 0);

    // full frame streamed with bytes 1..32
    start_feed(1, 32);
    prefill(1);
    pix.delete();
    for (int i = 0; i < 72; i++) begin
      if (i > 0) @(negedge pclk);
      hs_arr[i] = hsync; vs_arr[i] = vsync; uf_arr[i] = underflow;
      if (hsync) pix.push_back(dout);
    end
    for (int l = 0; l < 4; l++) begin
      hs_line = 0;
      for (int c = 0; c < 12; c++) hs_line += int'(hs_arr[l*12+c]);
      check("line_hsync_cycles", hs_line, 8);
      check("line_last_active", hs_arr[l*12+7], 1);
      check("line_first_blank", hs_arr[l*12+8], 0);
    end
    vs_tot = 0; uf_tot = 0;
    for (int i = 0; i < 72; i++) begin
      vs_tot += int'(vs_arr[i]); uf_tot += int'(uf_arr[i]);
    end
    check("vsync_cycles", vs_tot, 24);
    check("vsync_edge_before", vs_arr[47], 0);
    check("vsync_edge_after", vs_arr[48], 1);
    check("stream_underflows", uf_tot, 0);
    check("stream_count", pix.size(), 32);
    errs = 0;
    for (int i = 0; i < pix.size(); i++) if (pix[i] != 8'(i + 1)) errs++;
    check("stream_order", errs, 0);

    // only four bytes supplied
    reset_now();
    start_feed(1, 4);
    prefill(1);
    for (int i = 1; i < 8; i++) begin
      @(negedge pclk);
      check("short_dout", dout, (i < 4) ? i + 1 : 0);
      check("short_underflow", underflow, (i >= 4));
      check("short_hsync", hsync, 1);
    end
`ifdef WDEC_UNDERFLOW_CNT_EN
    check("short_ucnt", underflow_cnt, 4);
`endif

    // reset mid-line at hcnt=5 of line 2
    repeat (21) @(negedge pclk);
    check("pre_rst_hsync", hsync, 1);
    check("pre_rst_underflow", underflow, 1);
    reset_now();
    repeat (3) @(negedge pclk);
    check("post_rst_idle", hsync, 0);
    start_feed(9, 12);
    prefill(9);
    for (int i = 1; i < 8; i++) begin
      @(negedge pclk);
      check("refill_dout", dout, (i < 4) ? i + 9 : 0);
      check("refill_vsync", vsync, 0);
    end

`ifdef WDEC_UNDERFLOW_CNT_EN
    repeat (800) @(negedge pclk);
    check("ucnt_saturated", underflow_cnt, 255);
`endif

    @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wdecoder.md
WDECODER -- requirements
Module: wdecoder

Interface
REQ-001 H_ACTIVE, default 8, active pixels per line.
REQ-002 H_BLANK, default 4, blanking cycles per line.
REQ-003 V_ACTIVE, default 4, active lines per frame.
REQ-004 V_BLANK, default 2, blanking lines per frame.
REQ-005 pclk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 din  input  8  incoming pixel byte.
REQ-008 din_valid  input  1  din holds a valid byte.
REQ-009 din_ready  output  1  block accepts din this cycle.
REQ-010 vsync  output  1  high during vertical blanking lines.
REQ-011 hsync  output  1  high during active pixel cycles.
REQ-012 dout  output  8  regenerated pixel byte.
REQ-013 underflow  output  1  one-cycle pulse: active pixel with empty FIFO.

Function
REQ-014 The block SHALL buffer bytes in a 4-entry FIFO; a push occurs when din_valid && din_ready.
REQ-015 din_ready SHALL be high iff the FIFO holds fewer than 4 entries, including while in IDLE.
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 In IDLE, hcnt and vcnt SHALL stay at 0 and all video outputs SHALL be 0.
REQ-018 The FSM SHALL move IDLE->RUN on the edge after the FIFO count reaches 4; there is no RUN->IDLE transition except reset.
REQ-019 In RUN, hcnt SHALL count 0..H_ACTIVE+H_BLANK-1 every cycle and wrap to 0.
REQ-020 On each hcnt wrap, vcnt SHALL count 0..V_ACTIVE+V_BLANK-1 and wrap to 0.
REQ-021 A RUN cycle is active iff hcnt<H_ACTIVE && vcnt<V_ACTIVE.
REQ-022 On an active cycle, the FIFO SHALL pop if non-empty; dout SHALL show the popped byte and hsync SHALL be 1.
REQ-023 On an active cycle with an empty FIFO, there SHALL be no pop; dout SHALL be 0, hsync SHALL be 1 and underflow SHALL be 1.
REQ-024 A push and pop in the same cycle SHALL leave the count unchanged; a same-cycle push into an empty FIFO SHALL NOT bypass (the pop still sees empty).
REQ-025 vsync SHALL be 1 iff in RUN and vcnt>=V_ACTIVE; dout SHALL be 0 on all non-active cycles.
REQ-026 vsync, hsync, dout and underflow SHALL be registered: they reflect the counter state of the previous cycle (1-cycle latency).
REQ-027 Counter widths SHALL hold the parameter sums without overflow; FIFO pointers SHALL wrap modulo 4.

Reset
REQ-028 While rst_n=0: FSM=IDLE, FIFO empty, counters 0; vsync, hsync, dout and underflow 0; din_ready 1.
REQ-029 Assertion of rst_n mid-line SHALL clear outputs immediately, without waiting for a clock, and SHALL discard buffered bytes.

Configuration
REQ-030 With macro WDEC_UNDERFLOW_CNT_EN defined, output underflow_cnt (8 bits, reset 0) SHALL increment on each underflow pulse, saturate at 255, and clear only on reset.
REQ-031 Without WDEC_UNDERFLOW_CNT_EN, the underflow_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset check: rst_n=0, then release -> vsync=hsync=underflow=0, dout=0, din_ready=1, FSM in IDLE.
REQ-033 Prefill: push 1,2,3,4 on consecutive cycles -> din_ready=0 after the 4th push; RUN on the next edge; dout=1 with hsync=1 one cycle later.
REQ-034 Stream bytes 1..32 with no gaps (defaults) -> 4 lines, each with hsync high 8 cycles and low 4 cycles, carrying bytes in order; then vsync high for 24 cycles; no underflow.
REQ-035 Supply only bytes 1..4 -> line 0 shows dout 1,2,3,4 then 0,0,0,0 with underflow pulses on pixels 5..8; underflow_cnt=4 with the macro defined.
REQ-036 Drive rst_n=0 at hcnt=5 of line 2 -> outputs 0 with no clock edge, FIFO empty, IDLE; refill of 4 bytes restarts at hcnt=0, vcnt=0.
REQ-037 Macro defined, with the FIFO never fed after prefill for 300+ active cycles -> underflow_cnt saturates at 255.
